// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS32 pipeline.
// Computes logic/shift/arithmetic/HI-LO-move results combinationally from
// the ID/EX operands and forms the write-back record for EX/MEM. DIV/DIVU
// use an iterative restoring radix-2 divider that stalls the pipeline.
//
// Optional feature macro: EX_DIV_EN (defined: divider present;
// undefined: DIV/DIVU act as NOP and stallreq_o is tied low).
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   aluop_i/alusel_i  operation code and result class
//   reg1_i/reg2_i     operands (rs, rt or extended immediate)
//   wd_i/wreg_i       destination address / write enable
//   hi_i/lo_i         forwarded HI/LO values
//   wd_o/wreg_o/wdata_o  write-back record to EX/MEM
//   whilo_o/hi_o/lo_o    HI/LO write record
//   stallreq_o        stall request while a division is in progress
module ex_stage #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);

    localparam logic [7:0] OP_AND  = 8'b0010_0100, OP_OR   = 8'b0010_0101;
    localparam logic [7:0] OP_XOR  = 8'b0010_0110, OP_NOR  = 8'b0010_0111;
    localparam logic [7:0] OP_SLL  = 8'b0111_1100, OP_SRL  = 8'b0000_0010;
    localparam logic [7:0] OP_SRA  = 8'b0000_0011;
    localparam logic [7:0] OP_MFHI = 8'b0001_0000, OP_MTHI = 8'b0001_0001;
    localparam logic [7:0] OP_MFLO = 8'b0001_0010, OP_MTLO = 8'b0001_0011;
    localparam logic [7:0] OP_SLT  = 8'b0010_1010, OP_SLTU = 8'b0010_1011;
    localparam logic [7:0] OP_ADD  = 8'b0010_0000, OP_ADDU = 8'b0010_0001;
    localparam logic [7:0] OP_SUB  = 8'b0010_0010, OP_SUBU = 8'b0010_0011;
    localparam logic [7:0] OP_DIV  = 8'b0001_1010, OP_DIVU = 8'b0001_1011;

    localparam logic [2:0] SEL_NOP   = 3'b000, SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010, SEL_MOVE  = 3'b011;
    localparam logic [2:0] SEL_ARITH = 3'b100;

    localparam logic [4:0] NOP_REG_ADDR = 5'b00000;

    logic [31:0] logic_res, shift_res, arith_res, move_res;
    logic [31:0] reg2_eff, sum_res;
    logic        is_sub, ovf, is_div;

    always_comb begin
        logic_res = '0;
        shift_res = '0;
        arith_res = '0;
        move_res  = '0;
        is_div    = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
        is_sub    = (aluop_i == OP_SUB) || (aluop_i == OP_SUBU);
        reg2_eff  = is_sub ? (32'd0 - reg2_i) : reg2_i;
        sum_res   = reg1_i + reg2_eff;
        // Overflow judged on the effective (negated for SUB) second operand.
        ovf       = (reg1_i[31] == reg2_eff[31]) && (sum_res[31] != reg1_i[31]);

        case (aluop_i)
            OP_AND:  logic_res = reg1_i & reg2_i;
            OP_OR:   logic_res = reg1_i | reg2_i;
            OP_XOR:  logic_res = reg1_i ^ reg2_i;
            OP_NOR:  logic_res = ~(reg1_i | reg2_i);
            default: ;
        endcase

        case (aluop_i)
            OP_SLL:  shift_res = reg2_i << reg1_i[4:0];
            OP_SRL:  shift_res = reg2_i >> reg1_i[4:0];
            OP_SRA:  shift_res = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
            default: ;
        endcase

        case (aluop_i)
            OP_ADD, OP_ADDU, OP_SUB, OP_SUBU: arith_res = sum_res;
            OP_SLT:  arith_res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
            OP_SLTU: arith_res = {31'd0, reg1_i < reg2_i};
            default: ;
        endcase

        case (aluop_i)
            OP_MFHI: move_res = hi_i;
            OP_MFLO: move_res = lo_i;
            default: ;
        endcase
    end

    logic        div_stall, div_done;
    logic [31:0] div_hi, div_lo;

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_BYZERO, DIV_DONE} div_state_t;

    div_state_t  state, state_nxt;
    logic [31:0] quo, rem, dvsr;
    logic [5:0]  cnt;
    logic        neg_q, neg_r;
    logic        sgn1, sgn2;
    logic [31:0] mag1, mag2;
    logic [32:0] trial, diff;

    always_comb begin
        sgn1      = (aluop_i == OP_DIV) && reg1_i[31];
        sgn2      = (aluop_i == OP_DIV) && reg2_i[31];
        mag1      = sgn1 ? (32'd0 - reg1_i) : reg1_i;
        mag2      = sgn2 ? (32'd0 - reg2_i) : reg2_i;
        trial     = {rem, quo[31]};
        diff      = trial - {1'b0, dvsr};
        div_lo    = neg_q ? (32'd0 - quo) : quo;
        div_hi    = neg_r ? (32'd0 - rem) : rem;
        state_nxt = state;
        div_stall = 1'b0;
        div_done  = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (is_div) begin
                    div_stall = 1'b1;
                    state_nxt = (reg2_i == '0) ? DIV_BYZERO : DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                div_stall = 1'b1;
                if (cnt == 6'(DIV_CYCLES - 1)) state_nxt = DIV_DONE;
            end
            DIV_BYZERO: begin
                div_stall = 1'b1;
                state_nxt = DIV_DONE;
            end
            DIV_DONE: begin
                div_done  = 1'b1;
                state_nxt = DIV_IDLE;
            end
            default: state_nxt = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
            quo   <= '0;
            rem   <= '0;
            dvsr  <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                DIV_IDLE: begin
                    if (is_div) begin
                        quo   <= mag1;
                        dvsr  <= mag2;
                        rem   <= '0;
                        cnt   <= '0;
                        neg_q <= sgn1 ^ sgn2;
                        neg_r <= sgn1;
                    end
                end
                DIV_BUSY: begin
                    // Restoring step: keep the difference only if non-negative.
                    if (!diff[32]) begin
                        rem <= diff[31:0];
                        quo <= {quo[30:0], 1'b1};
                    end else begin
                        rem <= trial[31:0];
                        quo <= {quo[30:0], 1'b0};
                    end
                    cnt <= cnt + 6'd1;
                end
                DIV_BYZERO: begin
                    quo <= '0;
                    rem <= '0;
                end
                default: ;
            endcase
        end
    end
`else
    logic unused_div;

    always_comb begin
        div_stall  = 1'b0;
        div_done   = 1'b0;
        div_hi     = '0;
        div_lo     = '0;
        unused_div = clk ^ (DIV_CYCLES == 0);
    end
`endif

    always_comb begin
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = '0;
        whilo_o    = 1'b0;
        hi_o       = '0;
        lo_o       = '0;
        stallreq_o = div_stall;

        if (((aluop_i == OP_ADD) || (aluop_i == OP_SUB)) && ovf) wreg_o = 1'b0;
        if (is_div) wreg_o = 1'b0;

        case (alusel_i)
            SEL_LOGIC: wdata_o = logic_res;
            SEL_SHIFT: wdata_o = shift_res;
            SEL_ARITH: wdata_o = arith_res;
            SEL_MOVE:  wdata_o = move_res;
            default:   wdata_o = '0;
        endcase

        case (aluop_i)
            OP_MTHI: begin
                whilo_o = 1'b1;
                hi_o    = reg1_i;
                lo_o    = lo_i;
            end
            OP_MTLO: begin
                whilo_o = 1'b1;
                hi_o    = hi_i;
                lo_o    = reg1_i;
            end
            default: ;
        endcase

        if (div_done) begin
            whilo_o = 1'b1;
            hi_o    = div_hi;
            lo_o    = div_lo;
        end

        if (rst) begin
            wd_o       = NOP_REG_ADDR;
            wreg_o     = 1'b0;
            wdata_o    = '0;
            whilo_o    = 1'b0;
            hi_o       = '0;
            lo_o       = '0;
            stallreq_o = 1'b0;
        end
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS32 pipeline.
- Consumes the decoded operation and operands registered by the ID/EX pipeline register, and produces the write-back record for the EX/MEM register.
- Logic, shift, arithmetic and HI/LO-move results are combinational.
- DIV/DIVU run on an internal iterative radix-2 divider that stalls the pipeline until the quotient and remainder are ready.

Parameters:
- DIV_CYCLES, 32: number of quotient-bit iterations. Fixed at the data width; not intended to be overridden.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous reset, active-high (`RstEnable = 1'b1)
- aluop_i  in  8  `AluOpBus operation code (define.v encodings)
- alusel_i  in  3  `AluSelBus result class (logic/shift/arith/move/NOP)
- reg1_i  in  32  operand 1 (rs value)
- reg2_i  in  32  operand 2 (rt value or extended immediate)
- wd_i  in  5  destination register address
- wreg_i  in  1  destination write enable
- hi_i  in  32  current HI value, already forwarded from MEM/WB
- lo_i  in  32  current LO value, already forwarded from MEM/WB
- wd_o  out  5  destination address to EX/MEM
- wreg_o  out  1  destination write enable to EX/MEM
- wdata_o  out  32  result to EX/MEM
- whilo_o  out  1  HI/LO write enable
- hi_o  out  32  HI write data
- lo_o  out  32  LO write data
- stallreq_o  out  1  stall request to pipeline control

Behaviour:
- Reset: while rst=1, and combinationally for the duration of that cycle, all outputs are 0. wd_o = `NOPRegAddr. Divider FSM → IDLE; internal divider registers cleared.
- Reset asserted mid-division aborts the division. No HI/LO write occurs.
- Logic ops (AND/OR/XOR/NOR/LUI): bitwise on reg1_i/reg2_i.
- Shift ops (SLL/SRL/SRA): shift amount = reg1_i[4:0], shifting reg2_i. SRA replicates bit 31.
- Arithmetic ops:
  - ADD/ADDU/SUB/SUBU: mod 2^32.
  - SLT: signed compare; SLTU: unsigned compare; result 0 or 1.
  - ADD/SUB signed overflow (operand signs equal and result sign differs, evaluated after negating reg2 for SUB) forces wreg_o=0. No exception is raised.
- Move ops: MFHI → wdata_o=hi_i; MFLO → wdata_o=lo_i. MTHI → whilo_o=1, hi_o=reg1_i, lo_o=lo_i. MTLO → whilo_o=1, lo_o=reg1_i, hi_o=hi_i.
- wdata_o is selected by alusel_i. `EXE_RES_NOP → wdata_o=0.
- Non-divide results appear in the same cycle as the inputs (0 added latency).
- Divider FSM states: IDLE, BUSY, BYZERO, DONE.
  - IDLE: on DIV/DIVU with reg2_i≠0, latch the operands as magnitudes (signed DIV takes absolute values), record both signs, clear the counter, assert stallreq_o, and go to BUSY. With reg2_i=0, go to BYZERO.
  - BUSY: one restoring shift-subtract step per cycle, stallreq_o=1. After DIV_CYCLES steps, go to DONE.
  - BYZERO: stallreq_o=1 for one cycle, quotient=remainder=0, then go to DONE.
  - DONE: stallreq_o=0; whilo_o=1; lo_o=quotient, hi_o=remainder. For DIV, quotient is negated if the operand signs differ, and remainder takes the dividend's sign. Next state is IDLE.
- Total DIV stall: 33 cycles (normal) or 2 cycles (divide by zero). Results and whilo_o are valid in the cycle stallreq_o falls.
- Inputs are held stable by pipeline control while stallreq_o=1. The divider uses only latched operands, so input changes during BUSY are ignored.
- A DIV arriving in the cycle immediately after DONE starts a fresh division. Two back-to-back DIVs stall 33+33 cycles.
- DIV/DIVU never write the GPR: wreg_o=0.
- Unknown aluop: wdata_o=0, whilo_o=0; wreg_o follows wreg_i.

Optional Feature:
- Macro `EX_DIV_EN`.
- Defined: divider FSM present, behaving as above.
- Undefined: no FSM or divider registers. DIV/DIVU behave as NOP (whilo_o=0, wreg_o=0). stallreq_o is tied to 0.

Test Plan:
- AND reg1=0xF0F0F0F0, reg2=0x0FF00FF0, wd=3, wreg=1 → same cycle: wdata_o=0x00F000F0, wd_o=3, wreg_o=1, stallreq_o=0.
- SRA reg1=4, reg2=0x80000000 → wdata_o=0xF8000000. SLT reg1=0xFFFFFFFF, reg2=1 → wdata_o=1. SLTU with the same operands → 0.
- ADD reg1=0x7FFFFFFF, reg2=1, wreg=1 → wreg_o=0. ADDU with the same operands → wreg_o=1, wdata_o=0x80000000.
- DIV reg1=-7 (0xFFFFFFF9), reg2=2 → stallreq_o high 33 cycles. Then one cycle with whilo_o=1, lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
- DIVU reg1=100, reg2=7 → after 33 stall cycles: lo_o=14, hi_o=2. DIV with reg2=0 → 2 stall cycles, then whilo_o=1, hi_o=lo_o=0.
- Start DIVU 100/7, assert rst at stall cycle 10 → next cycle: stallreq_o=0, whilo_o=0. A new DIVU 9/3 then completes after 33 cycles with lo_o=3, hi_o=0.
